// File: rtl/mem_console_uart.sv
// mem_console_uart: picorv32 native-bus console with a TX FIFO and an 8N1 UART serialiser.
// Optional macro CONSOLE_SIM_PRINT_EN echoes every accepted TXDATA byte to the simulator console.
module mem_console_uart #(
    parameter logic [31:0] ADDR_BASE  = 32'h1000_0000,
    parameter int unsigned CLK_DIV    = 32'd16,
    parameter int unsigned FIFO_DEPTH = 32'd16
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        mem_valid,
    input  logic        mem_instr,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic        uart_tx,
    output logic        tx_idle
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 32'd1;
    localparam int unsigned DIV_W = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE_C  = CNT_W'(32'd1);
    localparam logic [PTR_W-1:0] PTR_ONE_C  = PTR_W'(32'd1);
    localparam logic [DIV_W-1:0] DIV_LAST_C = DIV_W'(CLK_DIV - 32'd1);
    localparam logic [DIV_W-1:0] DIV_ONE_C  = DIV_W'(32'd1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    logic [7:0]       fifo_mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_r, wr_ptr_s, rd_ptr_r, rd_ptr_s;
    logic [CNT_W-1:0] count_r, count_s;
    state_t           state_r, state_s;
    logic [DIV_W-1:0] bit_cnt_r, bit_cnt_s;
    logic [2:0]       idx_r, idx_s;
    logic [7:0]       shift_r, shift_s;
    logic             uart_tx_r, uart_tx_s;
    logic             tx_idle_r, tx_idle_s;
    logic             mem_ready_r, mem_ready_s;
    logic [31:0]      mem_rdata_r, mem_rdata_s;
    logic [31:0]      status_s;
    logic             sel_s, full_s, empty_s, busy_s, stall_s, push_s, pop_s, bit_end_s;
    logic             unused_s;

    assign unused_s = ^{mem_instr, mem_wdata[31:8], mem_addr[1:0]};

    // Bus decode, FIFO bookkeeping and serialiser next-state
    always_comb begin
        sel_s       = mem_valid && !mem_ready_r && (mem_addr[31:3] == ADDR_BASE[31:3]);
        full_s      = (count_r == DEPTH_C);
        empty_s     = (count_r == {CNT_W{1'b0}});
        busy_s      = (state_r != ST_IDLE);
        status_s    = {16'h0000, 8'(count_r), 5'b00000, busy_s, empty_s, full_s};
        // A TXDATA byte write into a full FIFO is held off; a same-edge pop does not help
        stall_s     = !mem_addr[2] && mem_wstrb[0] && full_s;
        push_s      = sel_s && !mem_addr[2] && mem_wstrb[0] && !full_s;
        mem_ready_s = sel_s && !stall_s;
        if (mem_ready_s && mem_addr[2] && (mem_wstrb == 4'b0000)) begin
            mem_rdata_s = status_s;
        end else begin
            mem_rdata_s = 32'h0000_0000;
        end

        pop_s     = 1'b0;
        state_s   = state_r;
        bit_cnt_s = bit_cnt_r;
        idx_s     = idx_r;
        shift_s   = shift_r;
        uart_tx_s = 1'b1;
        bit_end_s = (bit_cnt_r == DIV_LAST_C);
        case (state_r)
            ST_IDLE: begin
                if (!empty_s) begin
                    pop_s     = 1'b1;
                    shift_s   = fifo_mem_r[rd_ptr_r];
                    bit_cnt_s = {DIV_W{1'b0}};
                    idx_s     = 3'd0;
                    state_s   = ST_START;
                end else begin
                    state_s   = ST_IDLE;
                end
            end
            ST_START: begin
                uart_tx_s = 1'b0;
                if (bit_end_s) begin
                    bit_cnt_s = {DIV_W{1'b0}};
                    state_s   = ST_DATA;
                end else begin
                    bit_cnt_s = bit_cnt_r + DIV_ONE_C;
                end
            end
            ST_DATA: begin
                uart_tx_s = shift_r[0];
                if (bit_end_s) begin
                    bit_cnt_s = {DIV_W{1'b0}};
                    shift_s   = {1'b0, shift_r[7:1]};
                    if (idx_r == 3'd7) begin
                        state_s = ST_STOP;
                    end else begin
                        idx_s   = idx_r + 3'd1;
                    end
                end else begin
                    bit_cnt_s = bit_cnt_r + DIV_ONE_C;
                end
            end
            ST_STOP: begin
                if (bit_end_s) begin
                    bit_cnt_s = {DIV_W{1'b0}};
                    state_s   = ST_IDLE;
                end else begin
                    bit_cnt_s = bit_cnt_r + DIV_ONE_C;
                end
            end
            default: begin
                bit_cnt_s = {DIV_W{1'b0}};
                state_s   = ST_IDLE;
            end
        endcase

        if (push_s) begin
            wr_ptr_s = wr_ptr_r + PTR_ONE_C;
        end else begin
            wr_ptr_s = wr_ptr_r;
        end
        if (pop_s) begin
            rd_ptr_s = rd_ptr_r + PTR_ONE_C;
        end else begin
            rd_ptr_s = rd_ptr_r;
        end
        case ({push_s, pop_s})
            2'b10:   count_s = count_r + CNT_ONE_C;
            2'b01:   count_s = count_r - CNT_ONE_C;
            default: count_s = count_r;
        endcase
        tx_idle_s = (count_s == {CNT_W{1'b0}}) && (state_s == ST_IDLE);
    end

    // State, FIFO pointers and registered bus/serial outputs
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r     <= ST_IDLE;
            wr_ptr_r    <= {PTR_W{1'b0}};
            rd_ptr_r    <= {PTR_W{1'b0}};
            count_r     <= {CNT_W{1'b0}};
            bit_cnt_r   <= {DIV_W{1'b0}};
            idx_r       <= 3'd0;
            shift_r     <= 8'h00;
            uart_tx_r   <= 1'b1;
            tx_idle_r   <= 1'b1;
            mem_ready_r <= 1'b0;
            mem_rdata_r <= 32'h0000_0000;
        end else begin
            state_r     <= state_s;
            wr_ptr_r    <= wr_ptr_s;
            rd_ptr_r    <= rd_ptr_s;
            count_r     <= count_s;
            bit_cnt_r   <= bit_cnt_s;
            idx_r       <= idx_s;
            shift_r     <= shift_s;
            uart_tx_r   <= uart_tx_s;
            tx_idle_r   <= tx_idle_s;
            mem_ready_r <= mem_ready_s;
            mem_rdata_r <= mem_rdata_s;
        end
    end

    // FIFO storage; no reset needed since count gates every read
    always_ff @(posedge clk) begin
        if (resetn && push_s) begin
            fifo_mem_r[wr_ptr_r] <= mem_wdata[7:0];
        end
    end

`ifdef CONSOLE_SIM_PRINT_EN
    // Echo each accepted TXDATA byte to the simulator console
    always_ff @(posedge clk) begin
        if (resetn && push_s) begin
            $write("%c", mem_wdata[7:0]);
        end
    end
`else
    // Without the echo, the serial line is the only output path
`endif

    assign mem_ready = mem_ready_r;
    assign mem_rdata = mem_rdata_r;
    assign uart_tx   = uart_tx_r;
    assign tx_idle   = tx_idle_r;
endmodule

// File: tb/tb_mem_console_uart.sv
// Scoreboard bench for mem_console_uart: a timing-level reference model predicts every ack,
// STATUS word, tx_idle value and UART frame; monitors compare the DUT against it.
module tb_mem_console_uart;
    localparam int DIV   = 4;
    localparam int DEPTH = 16;
    localparam int FRAME = 10 * DIV;
    localparam logic [31:0] BASE = 32'h1000_0000;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        mem_valid = 1'b0;
    logic        mem_instr = 1'b0;
    logic [31:0] mem_addr = 32'h0;
    logic [31:0] mem_wdata = 32'h0;
    logic [3:0]  mem_wstrb = 4'h0;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        uart_tx;
    logic        tx_idle;

    always #5 clk = ~clk;

    mem_console_uart #(.ADDR_BASE(BASE), .CLK_DIV(DIV), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .resetn(resetn), .mem_valid(mem_valid), .mem_instr(mem_instr),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata), .uart_tx(uart_tx), .tx_idle(tx_idle)
    );

    // Edge counter: after posedge n, cyc == n
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int edge_n; logic [31:0] rdata; } bus_exp_t;
    typedef struct { int start_n; logic [7:0] data; } tx_exp_t;
    bus_exp_t bus_q[$];
    tx_exp_t  tx_q[$];
    int push_e[$];
    int pop_e[$];
    int n_cmp = 0;
    int n_bad = 0;
    int last_ack = -10;
    int epoch = 0;
    bit chk_idle = 1'b0;
    bus_exp_t mon_b;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: FIFO occupancy after edge n
    function automatic int cnt_after(int n);
        int c = 0;
        foreach (push_e[i]) if (push_e[i] <= n) c++;
        foreach (pop_e[i]) if (pop_e[i] <= n) c--;
        return c;
    endfunction

    // Model: serialiser is mid-frame after edge n (frame occupies FRAME edges from its pop)
    function automatic bit busy_after(int n);
        foreach (pop_e[i]) if (n >= pop_e[i] && n < pop_e[i] + FRAME) return 1'b1;
        return 1'b0;
    endfunction

    // Issue one bus access; caller is at a negedge. Expected ack edge and data go to the scoreboard.
    task automatic bus_op(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb,
                          input bit force_exp, input logic [31:0] exp_val);
        int n0, e, p, c;
        bit got;
        logic [31:0] rd;
        n0 = cyc + 1 + ((last_ack == cyc) ? 1 : 0);
        mem_valid = 1'b1;
        mem_instr = 1'($urandom_range(0, 1));
        mem_addr  = addr;
        mem_wdata = wdata;
        mem_wstrb = wstrb;
        if (addr[31:3] != BASE[31:3]) begin
            repeat (4) @(negedge clk);
            mem_valid = 1'b0;
            return;
        end
        e  = n0;
        rd = 32'h0;
        if (!addr[2] && wstrb[0]) begin
            while (cnt_after(e - 1) >= DEPTH && e < n0 + 5000) e++;
            p = e + 1;
            if (pop_e.size() > 0 && pop_e[$] + FRAME + 1 > p) p = pop_e[$] + FRAME + 1;
            push_e.push_back(e);
            pop_e.push_back(p);
            tx_q.push_back('{p + 1, wdata[7:0]});
        end else if (addr[2] && wstrb == 4'b0000) begin
            c  = cnt_after(e - 1);
            rd = {16'h0000, 8'(c), 5'b00000, busy_after(e - 1), (c == 0), (c == DEPTH)};
        end
        if (force_exp) rd = exp_val;
        bus_q.push_back('{e, rd});
        got = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (mem_ready === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) check("ack_timeout", 32'(cyc), 32'(e));
        last_ack  = cyc;
        mem_valid = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        mem_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Wait until the model says everything has drained, bounded
    task automatic wait_drain();
        mem_valid = 1'b0;
        for (int k = 0; k < 20000; k++) begin
            if (cnt_after(cyc) == 0 && !busy_after(cyc)) break;
            @(negedge clk);
        end
        repeat (4) @(negedge clk);
    endtask

    // Bus monitor: every ack must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (mem_ready === 1'b1) begin
            if (bus_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_ack: got ack addr %h expected none (cycle %0d)", mem_addr, cyc);
            end else begin
                mon_b = bus_q.pop_front();
                check("ack_cycle", 32'(cyc), 32'(mon_b.edge_n));
                check("rdata", mem_rdata, mon_b.rdata);
            end
        end else begin
            check("rdata_idle", mem_rdata, 32'h0);
        end
    end

    // tx_idle monitor against the model
    always @(negedge clk) begin
        if (chk_idle) check("tx_idle", {31'b0, tx_idle}, {31'b0, (cnt_after(cyc) == 0 && !busy_after(cyc))});
    end

    // UART monitor: decode each frame at bit centres and match the expected byte queue
    initial begin
        int s, ep;
        logic [7:0] got;
        logic start_b, stop_b;
        tx_exp_t t;
        forever begin
            @(negedge clk);
            if (resetn === 1'b1 && uart_tx === 1'b0) begin
                s  = cyc;
                ep = epoch;
                while (cyc < s + DIV / 2) @(negedge clk);
                start_b = uart_tx;
                for (int i = 0; i < 8; i++) begin
                    while (cyc < s + DIV * (i + 1) + DIV / 2) @(negedge clk);
                    got[i] = uart_tx;
                end
                while (cyc < s + 9 * DIV + DIV / 2) @(negedge clk);
                stop_b = uart_tx;
                if (ep == epoch) begin
                    if (tx_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_frame: got byte %h expected none (start %0d)", got, s);
                    end else begin
                        t = tx_q.pop_front();
                        check("frame_start", 32'(s), 32'(t.start_n));
                        check("start_bit", {31'b0, start_b}, 32'h0);
                        check("frame_data", {24'h0, got}, {24'h0, t.data});
                        check("stop_bit", {31'b0, stop_b}, 32'h1);
                    end
                end
            end
        end
    end

    initial begin
        logic [31:0] a, w;
        logic [3:0]  st;
        int r, gap;
        repeat (3) @(negedge clk);
        check("rst_ready", {31'b0, mem_ready}, 32'h0);
        check("rst_rdata", mem_rdata, 32'h0);
        check("rst_uart_tx", {31'b0, uart_tx}, 32'h1);
        check("rst_tx_idle", {31'b0, tx_idle}, 32'h1);
        resetn   = 1'b1;
        chk_idle = 1'b1;
        @(negedge clk);

        bus_op(BASE + 32'd4, 32'h0, 4'b0000, 1'b1, 32'h0000_0002);
        idle_cycles(3);

        bus_op(BASE, 32'h41, 4'b0001, 1'b0, 32'h0);
        wait_drain();

        for (int i = 0; i < 18; i++) bus_op(BASE, 32'(i), 4'b1111, 1'b0, 32'h0);
        wait_drain();

        for (int i = 0; i < 6; i++) bus_op(BASE, 32'h60 + 32'(i), 4'b0001, 1'b0, 32'h0);
        bus_op(BASE + 32'd4, 32'h0, 4'b0000, 1'b1, 32'h0000_0504);
        wait_drain();

        bus_op(BASE, 32'h5A, 4'b0010, 1'b0, 32'h0);
        bus_op(BASE + 32'd8, 32'h0, 4'b0000, 1'b0, 32'h0);
        idle_cycles(2);
        bus_op(BASE + 32'd4, 32'h0, 4'b0000, 1'b1, 32'h0000_0002);
        idle_cycles(5);

        for (int i = 0; i < 150; i++) begin
            r   = $urandom_range(0, 9);
            gap = $urandom_range(0, 3);
            if ($urandom_range(0, 9) == 0) gap = $urandom_range(20, 120);
            if (gap > 0) idle_cycles(gap);
            w  = $urandom;
            a  = BASE | 32'($urandom_range(0, 3));
            st = 4'($urandom_range(0, 15));
            case (r)
                0, 1, 2, 3, 4: bus_op(a, w, st | 4'b0001, 1'b0, 32'h0);
                5:             bus_op(a, w, st & 4'b1110, 1'b0, 32'h0);
                6:             bus_op(a | 32'd4, w, 4'b0000, 1'b0, 32'h0);
                7:             bus_op(a | 32'd4, w, st | 4'b0001, 1'b0, 32'h0);
                8:             bus_op(a, w, 4'b0000, 1'b0, 32'h0);
                default: begin
                    a = $urandom;
                    if (a[31:3] == BASE[31:3]) a = a ^ 32'h8000_0000;
                    bus_op(a, w, st, 1'b0, 32'h0);
                end
            endcase
        end
        wait_drain();
        check("tx_q_drained", 32'(tx_q.size()), 32'h0);

        for (int i = 0; i < 4; i++) bus_op(BASE, 32'hA0 + 32'(i), 4'b0001, 1'b0, 32'h0);
        idle_cycles(5);
        resetn   = 1'b0;
        chk_idle = 1'b0;
        epoch++;
        tx_q.delete();
        push_e.delete();
        pop_e.delete();
        @(negedge clk);
        check("midrst_uart_tx", {31'b0, uart_tx}, 32'h1);
        check("midrst_tx_idle", {31'b0, tx_idle}, 32'h1);
        resetn   = 1'b1;
        chk_idle = 1'b1;
        bus_op(BASE + 32'd4, 32'h0, 4'b0000, 1'b1, 32'h0000_0002);
        idle_cycles(150);
        check("bus_q_drained", 32'(bus_q.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
